spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: bits per serial word.
REQ-002 SHALL have parameter CPOL, default 0: SCK idle level.
REQ-003 SHALL have parameter CPHA, default 1: 0 = sample on leading edge, 1 = sample on trailing edge.
REQ-004 SHALL have parameter LSBF, default 0: 0 = MSB first, 1 = LSB first.
REQ-005 SHALL have port clk, input, 1 bit: single system clock, rising-edge active.
REQ-006 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port SCK, input, 1 bit: serial clock from the master, asynchronous to clk.
REQ-008 SHALL have port SS, input, 1 bit: slave select, active-low, asynchronous to clk.
REQ-009 SHALL have port MOSI, input, 1 bit: serial data from the master.
REQ-010 SHALL have port MISO, output, 1 bit: serial data to the master.
REQ-011 SHALL have port data_in, input, DATA_BITS: transmit word for the next transfer.
REQ-012 SHALL have port load_en, input, 1 bit: writes data_in into the TX buffer.
REQ-013 SHALL have port ready_out, output, 1 bit: TX buffer empty and accepting a load.
REQ-014 SHALL have port data_out, output, DATA_BITS: last completely received word.
REQ-015 SHALL have port valid_out, output, 1 bit: one-cycle pulse marking that data_out was updated.

Function
REQ-016 SHALL pass SCK, SS and MOSI each through a 2-flop synchronizer and detect edges by comparing the synchronized value with a third, delayed flop.
REQ-017 SHALL define the leading edge as a synchronized SCK transition away from CPOL and the trailing edge as the transition back to CPOL.
REQ-018 SHALL implement states IDLE, SHIFT and DONE.
- IDLE -> SHIFT on a synchronized SS falling edge.
- SHIFT -> DONE on the DATA_BITS-th sample edge.
- DONE -> SHIFT after one cycle if synchronized SS is low; otherwise DONE -> IDLE.
REQ-019 On every entry to SHIFT, SHALL copy the TX buffer into the TX shift register, set ready_out=1 and clear the bit counter.
- If the buffer is empty, the TX shift register SHALL be loaded with all zeros.
REQ-020 TX buffer handshake: load_en=1 while ready_out=1 SHALL capture data_in and drive ready_out=0 on the next cycle; load_en while ready_out=0 SHALL be ignored.
REQ-021 MISO SHALL present the MSB (LSBF=0) or LSB (LSBF=1) of the TX shift register.
- CPHA=0: the first bit is valid from SHIFT entry; the register shifts on each trailing edge.
- CPHA=1: the register shifts on each leading edge except the first.
REQ-022 SHALL sample the synchronized MOSI into the RX shift register on each sample edge, entering at the LSB (LSBF=0) or the MSB (LSBF=1).
REQ-023 On the DATA_BITS-th sample, SHALL load data_out with the completed word and assert valid_out for exactly one clk cycle, on the cycle after the sample edge is detected.
REQ-024 A synchronized SS rising edge during SHIFT SHALL abort the transfer: discard the partial word, leave data_out unchanged, assert no valid_out and go to IDLE.
REQ-025 SCK edges while SS is high SHALL be ignored.
REQ-026 The bit counter SHALL be ceil(log2(DATA_BITS)) bits wide and SHALL wrap to 0 at each word boundary.
REQ-027 Correct operation SHALL require an SCK half-period of at least 4 clk cycles.

Reset
REQ-028 While n_rst=0, SHALL hold: state=IDLE, ready_out=1, valid_out=0, data_out=0, both shift registers=0, TX buffer empty, synchronizers at SCK=CPOL, SS=1, MOSI=0.
REQ-029 Reset asserted mid-transfer SHALL take effect immediately and the aborted word SHALL never be reported.

Configuration
REQ-030 The macro SPI_SLAVE_MISO_TRISTATE_EN SHALL control how MISO behaves while the slave is deselected.
- Defined: MISO is high-impedance whenever synchronized SS is high or the state is IDLE.
- Undefined: MISO is driven 0 in those conditions.

Verification
REQ-031 CPOL=0, CPHA=1, MSB first: master sends 0xA5 while data_in=0x3C is loaded -> data_out=0xA5, one valid_out pulse, MISO bit stream 0,0,1,1,1,1,0,0.
REQ-032 CPHA=0, LSBF=1: master sends 0x81 -> data_out=0x81; the first MISO bit is valid before the first SCK edge.
REQ-033 SS held low across three words 0x01, 0x02, 0x03 -> three valid_out pulses in order; ready_out returns to 1 at each word start.
REQ-034 SS released after 5 bits -> no valid_out, data_out keeps its previous value, state returns to IDLE.
REQ-035 No load before SS falls -> MISO sends 0x00; load_en while ready_out=0 -> the buffer still holds its first value.
REQ-036 n_rst pulsed low mid-word -> all outputs at reset values; the next full word 0x5A is received correctly.

Source files
------------

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//   SPI slave that runs entirely in the clk domain. SCK, SS and MOSI are
//   oversampled through 2-flop synchronizers. SCK and SS also get a third,
//   delayed flop used for edge detection. One DATA_BITS word is exchanged
//   per frame, and frames may run back to back while SS stays low. The SCK
//   half-period must be at least 4 clk cycles.
//
// Parameters
//   DATA_BITS : bits per serial word (>= 2)
//   CPOL      : SCK idle level
//   CPHA      : 0 = sample on leading edge, 1 = sample on trailing edge
//   LSBF      : 0 = MSB first, 1 = LSB first
//
// Ports
//   clk       in   system clock, rising edge
//   n_rst     in   asynchronous active-low reset
//   SCK       in   serial clock from master (asynchronous)
//   SS        in   slave select, active low (asynchronous)
//   MOSI      in   serial data from master
//   MISO      out  serial data to master
//   data_in   in   transmit word for the next transfer
//   load_en   in   write data_in into the TX buffer (taken only when ready_out)
//   ready_out out  TX buffer empty and accepting a load
//   data_out  out  last completely received word
//   valid_out out  one-cycle pulse when data_out is updated
//
// Build option
//   SPI_SLAVE_MISO_TRISTATE_EN : when defined, MISO is high-impedance while
//   deselected or idle. Otherwise MISO is driven low in that condition.
// ---------------------------------------------------------------------------
module spi_slave #(
    parameter int DATA_BITS = 8,
    parameter int CPOL      = 0,
    parameter int CPHA      = 1,
    parameter int LSBF      = 0
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 SCK,
    input  logic                 SS,
    input  logic                 MOSI,
    output logic                 MISO,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 load_en,
    output logic                 ready_out,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out
);

    localparam int             CW     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0]  LAST   = CW'(DATA_BITS - 1);
    localparam logic           L_CPOL = (CPOL != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    // synchronizers
    logic r_sck_s1, r_sck_s2, r_sck_d;
    logic r_ss_s1,  r_ss_s2,  r_ss_d;
    logic r_mosi_s1, r_mosi_s2;

    // datapath
    logic [DATA_BITS-1:0] r_tx_buf;
    logic                 r_tx_full;
    logic [DATA_BITS-1:0] r_tx;
    logic [DATA_BITS-1:0] r_rx;
    logic [CW-1:0]        r_cnt;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;

    logic                 w_lead, w_trail, w_ss_fall;
    logic                 w_active, w_sample, w_shift, w_last, w_enter;
    logic                 w_tx_bit, w_quiet;
    logic [DATA_BITS-1:0] w_rx_next, w_tx_next;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sck_s1  <= L_CPOL;
            r_sck_s2  <= L_CPOL;
            r_sck_d   <= L_CPOL;
            r_ss_s1   <= 1'b1;
            r_ss_s2   <= 1'b1;
            r_ss_d    <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_sck_s1  <= SCK;
            r_sck_s2  <= r_sck_s1;
            r_sck_d   <= r_sck_s2;
            r_ss_s1   <= SS;
            r_ss_s2   <= r_ss_s1;
            r_ss_d    <= r_ss_s2;
            r_mosi_s1 <= MOSI;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    assign w_lead    = (r_sck_d == L_CPOL) && (r_sck_s2 != L_CPOL);
    assign w_trail   = (r_sck_d != L_CPOL) && (r_sck_s2 == L_CPOL);
    assign w_ss_fall = r_ss_d && !r_ss_s2;

    // SCK edges only count while selected and shifting.
    assign w_active = (r_state == SHIFT) && !r_ss_s2;
    assign w_sample = w_active && ((CPHA == 0) ? w_lead : w_trail);
    assign w_last   = w_sample && (r_cnt == LAST);

    // The counter is zero only before the first sample of a word. This
    // suppresses the CPHA=1 first leading edge. For CPHA=0 it also swallows
    // the previous word's final trailing edge when frames run back to back.
    assign w_shift  = w_active && (r_cnt != '0) && ((CPHA == 0) ? w_trail : w_lead);

    assign w_rx_next = (LSBF != 0) ? {r_mosi_s2, r_rx[DATA_BITS-1:1]}
                                   : {r_rx[DATA_BITS-2:0], r_mosi_s2};
    assign w_tx_next = (LSBF != 0) ? {1'b0, r_tx[DATA_BITS-1:1]}
                                   : {r_tx[DATA_BITS-2:0], 1'b0};
    assign w_tx_bit  = (LSBF != 0) ? r_tx[0] : r_tx[DATA_BITS-1];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_ss_fall) w_next = SHIFT;
            SHIFT: begin
                // Deselect mid-word abandons the partial word.
                if (r_ss_s2)     w_next = IDLE;
                else if (w_last) w_next = DONE;
            end
            DONE:    w_next = r_ss_s2 ? IDLE : SHIFT;
            default: w_next = IDLE;
        endcase
    end

    assign w_enter = (w_next == SHIFT) && (r_state != SHIFT);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tx_buf  <= '0;
            r_tx_full <= 1'b0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_last;
            if (w_last) begin
                r_data <= w_rx_next;
            end
            if (w_sample) begin
                r_rx  <= w_rx_next;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_shift) begin
                r_tx <= w_tx_next;
            end
            if (w_enter) begin
                r_tx      <= r_tx_full ? r_tx_buf : '0;
                r_tx_full <= 1'b0;
                r_cnt     <= '0;
            end
            // Placed after the word-start update so a load into an empty
            // buffer on the same cycle is kept for the following word.
            if (load_en && !r_tx_full) begin
                r_tx_buf  <= data_in;
                r_tx_full <= 1'b1;
            end
        end
    end

    assign w_quiet   = r_ss_s2 || (r_state == IDLE);
    assign ready_out = !r_tx_full;
    assign data_out  = r_data;
    assign valid_out = r_valid;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign MISO = w_quiet ? 1'bz : w_tx_bit;
`else
    assign MISO = w_quiet ? 1'b0 : w_tx_bit;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
//   Instance A: CPOL=0 CPHA=1 MSB first. Instance B: CPOL=1 CPHA=0 LSB first.
//   The bench acts as SPI master for both instances. Its reference is a
//   word-level model: a received word equals the sent MOSI word. A transmitted
//   word equals the TX buffer content when the word starts, or zero if the
//   buffer is empty. Each word start empties the buffer.
// ---------------------------------------------------------------------------
module tb_spi_slave;

    localparam int H = 6;  // SCK half-period in clk cycles

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    logic       sck_a, ss_a, mosi_a, miso_a, load_a, ready_a, valid_a;
    logic [7:0] din_a, dout_a;
    logic       sck_b, ss_b, mosi_b, miso_b, load_b, ready_b, valid_b;
    logic [7:0] din_b, dout_b;

    spi_slave #(.DATA_BITS(8), .CPOL(0), .CPHA(1), .LSBF(0)) u_a (
        .clk(clk), .n_rst(n_rst), .SCK(sck_a), .SS(ss_a), .MOSI(mosi_a),
        .MISO(miso_a), .data_in(din_a), .load_en(load_a), .ready_out(ready_a),
        .data_out(dout_a), .valid_out(valid_a)
    );

    spi_slave #(.DATA_BITS(8), .CPOL(1), .CPHA(0), .LSBF(1)) u_b (
        .clk(clk), .n_rst(n_rst), .SCK(sck_b), .SS(ss_b), .MOSI(mosi_b),
        .MISO(miso_b), .data_in(din_b), .load_en(load_b), .ready_out(ready_b),
        .data_out(dout_b), .valid_out(valid_b)
    );

    int total = 0;
    int bad   = 0;

    // reference model state, per instance
    logic [7:0] mb[2];
    bit         mf[2];
    logic [7:0] cur[2];
    logic [7:0] last[2];

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always @(negedge clk) begin
        if (valid_a) qa.push_back(dout_a);
        if (valid_b) qb.push_back(dout_b);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic set_sck(input int d, input logic v);
        if (d == 0) sck_a = v; else sck_b = v;
    endtask
    task automatic set_ss(input int d, input logic v);
        if (d == 0) ss_a = v; else ss_b = v;
    endtask
    task automatic set_mosi(input int d, input logic v);
        if (d == 0) mosi_a = v; else mosi_b = v;
    endtask
    function automatic logic miso_of(input int d);
        return (d == 0) ? miso_a : miso_b;
    endfunction
    function automatic logic ready_of(input int d);
        return (d == 0) ? ready_a : ready_b;
    endfunction
    function automatic logic [7:0] dout_of(input int d);
        return (d == 0) ? dout_a : dout_b;
    endfunction

    task automatic start_word(input int d);
        cur[d] = mf[d] ? mb[d] : 8'h00;
        mf[d]  = 1'b0;
    endtask

    task automatic do_load(input int d, input logic [7:0] v);
        chk("ready_before_load", ready_of(d), !mf[d]);
        if (!mf[d]) begin
            mb[d] = v;
            mf[d] = 1'b1;
        end
        if (d == 0) begin din_a = v; load_a = 1'b1; end
        else        begin din_b = v; load_b = 1'b1; end
        cyc(1);
        if (d == 0) load_a = 1'b0; else load_b = 1'b0;
        chk("ready_after_load", ready_of(d), 1'b0);
    endtask

    task automatic begin_sel(input int d);
        set_ss(d, 1'b0);
        cyc(8);
        start_word(d);
    endtask

    task automatic end_sel(input int d);
        set_ss(d, 1'b1);
        cyc(8);
    endtask

    // One word as master. SS stays low afterwards, so a completed word is
    // followed by the slave starting the next word on its own.
    task automatic word(input int d, input logic [7:0] mo, input int nbits,
                        input bit ld, input logic [7:0] ldv, output logic [7:0] mi);
        logic cp, ph, lf;
        cp = (d == 1);
        ph = (d == 0);
        lf = (d == 1);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            int b;
            if (ld && i == 2) do_load(d, ldv);
            b = lf ? i : 7 - i;
            if (!ph) begin
                set_mosi(d, mo[b]);
                cyc(H);
                mi[b] = miso_of(d);
                set_sck(d, !cp);
                cyc(H);
                set_sck(d, cp);
            end else begin
                set_sck(d, !cp);
                set_mosi(d, mo[b]);
                cyc(H);
                mi[b] = miso_of(d);
                set_sck(d, cp);
            end
            cyc(H);
        end
        if (nbits == 8) start_word(d);
    endtask

    task automatic expect_word(input int d, input logic [7:0] exp);
        int n;
        logic [7:0] v;
        v = 8'h00;
        if (d == 0) begin
            n = qa.size();
            if (n > 0) v = qa[0];
            qa.delete();
        end else begin
            n = qb.size();
            if (n > 0) v = qb[0];
            qb.delete();
        end
        chk("valid_pulses", n, 1);
        if (n > 0) chk("valid_word", v, exp);
        chk("data_out", dout_of(d), exp);
        last[d] = exp;
    endtask

    typedef struct {
        int         d;
        bit         pre;
        logic [7:0] tx;
        logic [7:0] mo;
        logic [7:0] emi;
        logic [7:0] edo;
    } vec_t;

    vec_t tbl[6];

    initial begin
        logic [7:0] mi;
        tbl[0] = '{0, 1'b1, 8'h3C, 8'hA5, 8'h3C, 8'hA5};
        tbl[1] = '{1, 1'b1, 8'h5B, 8'h81, 8'h5B, 8'h81};
        tbl[2] = '{0, 1'b0, 8'h00, 8'h5A, 8'h00, 8'h5A};
        tbl[3] = '{1, 1'b0, 8'h00, 8'h3E, 8'h00, 8'h3E};
        tbl[4] = '{0, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00};
        tbl[5] = '{1, 1'b1, 8'h01, 8'h80, 8'h01, 8'h80};

        sck_a = 1'b0; ss_a = 1'b1; mosi_a = 1'b0; load_a = 1'b0; din_a = 8'h00;
        sck_b = 1'b1; ss_b = 1'b1; mosi_b = 1'b0; load_b = 1'b0; din_b = 8'h00;
        for (int k = 0; k < 2; k++) begin
            mf[k] = 1'b0; mb[k] = 8'h00; cur[k] = 8'h00; last[k] = 8'h00;
        end
        n_rst = 1'b0;
        cyc(3);
        chk("rst_ready_a", ready_a, 1'b1);
        chk("rst_valid_a", valid_a, 1'b0);
        chk("rst_dout_a", dout_a, 8'h00);
        chk("rst_miso_a", miso_a, 1'b0);
        chk("rst_ready_b", ready_b, 1'b1);
        chk("rst_dout_b", dout_b, 8'h00);
        chk("rst_miso_b", miso_b, 1'b0);
        n_rst = 1'b1;
        cyc(4);

        // directed vectors
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].pre) do_load(tbl[i].d, tbl[i].tx);
            begin_sel(tbl[i].d);
            if (tbl[i].d == 1) chk("first_bit_before_sck", miso_b, tbl[i].tx[0]);
            word(tbl[i].d, tbl[i].mo, 8, 1'b0, 8'h00, mi);
            chk("tbl_miso", mi, tbl[i].emi);
            expect_word(tbl[i].d, tbl[i].edo);
            end_sel(tbl[i].d);
        end

        // three back-to-back words, next TX word loaded mid-word each time
        do_load(0, 8'h11);
        begin_sel(0);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] nx;
            nx = (k == 0) ? 8'h22 : 8'h33;
            chk("ready_word_start", ready_a, 1'b1);
            word(0, 8'(k + 1), 8, (k < 2), nx, mi);
            chk("multi_miso", mi, 8'(8'h11 * (k + 1)));
            expect_word(0, 8'(k + 1));
        end
        end_sel(0);

        // load while full is ignored
        do_load(0, 8'h66);
        do_load(0, 8'h99);
        begin_sel(0);
        word(0, 8'h4D, 8, 1'b0, 8'h00, mi);
        chk("ignored_load", mi, 8'h66);
        expect_word(0, 8'h4D);
        end_sel(0);

        // deselect after 5 bits
        begin_sel(0);
        word(0, 8'hC7, 5, 1'b0, 8'h00, mi);
        end_sel(0);
        chk("abort_no_valid", qa.size(), 0);
        chk("abort_hold", dout_a, 8'h4D);
        chk("abort_miso_idle", miso_a, 1'b0);
        begin_sel(0);
        word(0, 8'h96, 8, 1'b0, 8'h00, mi);
        chk("after_abort_miso", mi, 8'h00);
        expect_word(0, 8'h96);
        end_sel(0);

        // reset in the middle of a word
        do_load(0, 8'h77);
        begin_sel(0);
        word(0, 8'hE1, 4, 1'b0, 8'h00, mi);
        n_rst = 1'b0;
        #1;
        chk("midrst_ready", ready_a, 1'b1);
        chk("midrst_valid", valid_a, 1'b0);
        chk("midrst_dout", dout_a, 8'h00);
        chk("midrst_miso", miso_a, 1'b0);
        chk("midrst_dout_b", dout_b, 8'h00);
        set_ss(0, 1'b1);
        set_sck(0, 1'b0);
        cyc(3);
        n_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            mf[k] = 1'b0; last[k] = 8'h00;
        end
        cyc(4);
        chk("midrst_no_valid", qa.size(), 0);
        begin_sel(0);
        word(0, 8'h5A, 8, 1'b0, 8'h00, mi);
        chk("post_rst_miso", mi, 8'h00);
        expect_word(0, 8'h5A);
        end_sel(0);

        // randomized transfers against the word-level model
        for (int it = 0; it < 24; it++) begin
            int d;
            logic [7:0] mo, em;
            bit ld;
            d  = $urandom_range(0, 1);
            mo = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_load(d, 8'($urandom));
            if ($urandom_range(0, 3) == 0) do_load(d, 8'($urandom));
            begin_sel(d);
            em = cur[d];
            ld = ($urandom_range(0, 1) == 1);
            word(d, mo, 8, ld, 8'($urandom), mi);
            chk("rnd_miso", mi, em);
            expect_word(d, mo);
            end_sel(d);
            chk("rnd_idle_dout", dout_of(d), last[d]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
